// File: rtl/soc_system_led_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : soc_system_led_sequencer_pkg
// Brief    : CSR map, bit positions and FSM encodings for the LED sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package soc_system_led_sequencer_pkg;

    localparam logic [3:0] c_addr_ctrl       = 4'd0;
    localparam logic [3:0] c_addr_status     = 4'd1;
    localparam logic [3:0] c_addr_prescale   = 4'd2;
    localparam logic [3:0] c_addr_length     = 4'd3;
    localparam logic [3:0] c_addr_manual     = 4'd4;
    localparam logic [3:0] c_addr_table_base = 4'd8;

    localparam int c_ctrl_run      = 0;
    localparam int c_ctrl_loop     = 1;
    localparam int c_stat_busy     = 0;
    localparam int c_stat_idx_lsb  = 4;
    localparam int c_stat_done     = 8;
    localparam int c_stat_reject   = 9;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_write = 2'd1;
    localparam logic [1:0] c_st_dwell = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [1:0] c_pio_data_addr = 2'd0;

endpackage

`default_nettype wire

// File: rtl/soc_system_led_seq_prescaler.sv
//------------------------------------------------------------------------------
// Module   : soc_system_led_seq_prescaler
// Brief    : Free-running tick prescaler; ticks every PRESCALE+1 cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module soc_system_led_seq_prescaler
    import soc_system_led_sequencer_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_count;

    // >= keeps a lowered PRESCALE from stalling until the counter wraps
    assign tick = !clear && (r_count >= prescale);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/soc_system_led_sequencer.sv
//------------------------------------------------------------------------------
// Module   : soc_system_led_sequencer
// Brief    : CSR slave + PIO write master that plays a (pattern, dwell) table.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module soc_system_led_sequencer
    import soc_system_led_sequencer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int LED_W      = 5,
    parameter int DWELL_W    = 16,
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [1:0]  m_address,
    output logic [31:0] m_writedata
);

    localparam logic [3:0] c_depth = 4'(DEPTH);

    logic [1:0]            r_state, w_state_nxt;
    logic [2:0]            r_index, w_index_nxt;
    logic [DWELL_W-1:0]    r_dwell_cnt, w_dwell_nxt;
    logic                  r_run, r_loop, r_done, r_reject;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [3:0]            r_length;
    logic [LED_W-1:0]      r_pat [DEPTH];
    logic [DWELL_W-1:0]    r_dwl [DEPTH];
    logic                  r_m_cs, r_m_wr_n;
    logic [31:0]           r_m_data;

    logic w_wr, w_ctrl_wr, w_man_wr, w_busy, w_abort, w_tick, w_last;
    logic w_set_done, w_clear_run, w_seq_wr, w_man_issue;
    logic [3:0]         w_eff_len;
    logic [DWELL_W-1:0] w_dwell_sel, w_dwell_load;
    logic               w_unused;

    assign w_wr        = chipselect && !write_n;
    assign w_ctrl_wr   = w_wr && (address == c_addr_ctrl);
    assign w_man_wr    = w_wr && (address == c_addr_manual);
    assign w_busy      = (r_state != c_st_idle);
    assign w_abort     = w_ctrl_wr && !writedata[c_ctrl_run] && w_busy;
    assign w_eff_len   = (r_length > c_depth) ? c_depth : r_length;
    // Also true when LENGTH was lowered under the running index
    assign w_last      = (({1'b0, r_index} + 4'd1) >= w_eff_len);
    assign w_dwell_sel = r_dwl[r_index];
    assign w_dwell_load = (w_dwell_sel == '0) ? DWELL_W'(1) : w_dwell_sel;
    assign w_seq_wr    = (w_state_nxt == c_st_write);
    assign w_man_issue = w_man_wr && !w_busy;
    assign w_unused    = &{1'b0, writedata[15:10], writedata[7:5]};

    soc_system_led_seq_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (r_state != c_st_dwell),
        .prescale (r_prescale),
        .tick     (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_dwell_nxt = r_dwell_cnt;
        w_set_done  = 1'b0;
        w_clear_run = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_ctrl_wr && writedata[c_ctrl_run] && (r_length != 4'd0)) begin
                    w_state_nxt = c_st_write;
                    w_index_nxt = 3'd0;
                end
            end
            c_st_write: begin
                w_dwell_nxt = w_dwell_load;
                w_state_nxt = w_abort ? c_st_idle : c_st_dwell;
            end
            c_st_dwell: begin
                if (w_abort) begin
                    w_state_nxt = c_st_idle;
                end else if (w_tick) begin
                    if (r_dwell_cnt <= DWELL_W'(1)) begin
                        if (!w_last) begin
                            w_index_nxt = r_index + 3'd1;
                            w_state_nxt = c_st_write;
                        end else if (r_loop) begin
                            w_index_nxt = 3'd0;
                            w_state_nxt = c_st_write;
                        end else begin
                            w_state_nxt = c_st_done;
                        end
                    end else begin
                        w_dwell_nxt = r_dwell_cnt - DWELL_W'(1);
                    end
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
                w_set_done  = !w_abort;
                w_clear_run = 1'b1;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_index     <= '0;
            r_dwell_cnt <= '0;
            r_run       <= 1'b0;
            r_loop      <= 1'b0;
            r_done      <= 1'b0;
            r_reject    <= 1'b0;
            r_prescale  <= '0;
            r_length    <= 4'd1;
            r_m_cs      <= 1'b0;
            r_m_wr_n    <= 1'b1;
            r_m_data    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pat[i] <= '0;
                r_dwl[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_dwell_cnt <= w_dwell_nxt;
            if (w_wr && (address == c_addr_prescale)) r_prescale <= writedata[PRESCALE_W-1:0];
            if (w_wr && (address == c_addr_length))   r_length   <= writedata[3:0];
            if (w_ctrl_wr) begin
                r_run  <= writedata[c_ctrl_run];
                r_loop <= writedata[c_ctrl_loop];
            end
            if (w_clear_run) r_run <= 1'b0;
            if (w_wr && (address == c_addr_status)) begin
                if (writedata[c_stat_done])   r_done   <= 1'b0;
                if (writedata[c_stat_reject]) r_reject <= 1'b0;
            end
            if (w_set_done)            r_done   <= 1'b1;
            if (w_man_wr && w_busy)    r_reject <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr && (address == (c_addr_table_base + 4'(i)))) begin
                    r_pat[i] <= writedata[LED_W-1:0];
                    r_dwl[i] <= writedata[16 +: DWELL_W];
                end
            end
            r_m_cs   <= w_seq_wr || w_man_issue;
            r_m_wr_n <= !(w_seq_wr || w_man_issue);
            if (w_seq_wr) begin
                r_m_data <= 32'(r_pat[w_index_nxt]);
            end else if (w_man_issue) begin
                r_m_data <= 32'(writedata[LED_W-1:0]);
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            c_addr_ctrl: begin
                readdata[c_ctrl_run]  = r_run;
                readdata[c_ctrl_loop] = r_loop;
            end
            c_addr_status: begin
                readdata[c_stat_busy]                = w_busy;
                readdata[c_stat_idx_lsb +: 3]        = r_index;
                readdata[c_stat_done]                = r_done;
                readdata[c_stat_reject]              = r_reject;
            end
            c_addr_prescale: readdata[PRESCALE_W-1:0] = r_prescale;
            c_addr_length:   readdata[3:0]            = r_length;
            default: begin
                if (address[3] && ({1'b0, address[2:0]} < c_depth)) begin
                    readdata[LED_W-1:0]     = r_pat[address[2:0]];
                    readdata[16 +: DWELL_W] = r_dwl[address[2:0]];
                end
            end
        endcase
    end

    assign m_chipselect = r_m_cs;
    assign m_write_n    = r_m_wr_n;
    assign m_address    = c_pio_data_addr;
    assign m_writedata  = r_m_data;

endmodule

`default_nettype wire

// File: tb/tb_soc_system_led_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_soc_system_led_sequencer
// Brief    : Directed self-checking bench for the LED sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_soc_system_led_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        m_chipselect, m_write_n;
    logic [1:0]  m_address;
    logic [31:0] m_writedata;

    soc_system_led_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_address    (m_address),
        .m_writedata  (m_writedata)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          back2back = 0;
    int          bad_addr = 0;
    logic        prev_strobe = 1'b0;
    logic [31:0] log_data[$];
    int          log_cyc[$];
    int          last_wr_cyc;

    always @(posedge clk) cyc++;

    // Cycle label at a negedge equals cyc, which stimulus sees at negedge+2
    always @(negedge clk) begin
        if (m_chipselect && !m_write_n) begin
            log_data.push_back(m_writedata);
            log_cyc.push_back(cyc);
            if (prev_strobe) back2back++;
            if (m_address != 2'd0) bad_addr++;
        end
        prev_strobe = m_chipselect && !m_write_n;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        step();
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        last_wr_cyc = cyc;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, log_data.size(), n);
    endtask

    initial begin
        logic [31:0] rd;
        int k;
        int c;

        // Reset
        step(); step();
        check("rst_cs", {31'd0, m_chipselect}, 32'd0);
        check("rst_wr_n", {31'd0, m_write_n}, 32'd1);
        check("rst_wdata", m_writedata, 32'd0);
        reset_n = 1'b1;
        csr_read(4'd1, rd);  check("rst_status", rd, 32'd0);
        csr_read(4'd3, rd);  check("rst_length", rd, 32'd1);
        csr_read(4'd0, rd);  check("rst_ctrl", rd, 32'd0);
        check("rst_no_pio", log_data.size(), 0);

        // One-shot two-entry run
        csr_write(4'd8, 32'h0002_0015);
        csr_write(4'd9, 32'h0001_000A);
        csr_read(4'd9, rd);  check("tbl1_rd", rd, 32'h0001_000A);
        csr_write(4'd3, 32'd2);
        csr_write(4'd2, 32'd0);
        clear_log();
        csr_write(4'd0, 32'd1);
        c = last_wr_cyc;
        wait_writes("os_nwr", 2, 20);
        check("os_first_lat", log_cyc[0] - c, 1);
        check("os_d0", log_data[0], 32'h15);
        check("os_d1", log_data[1], 32'h0A);
        check("os_gap", log_cyc[1] - log_cyc[0], 3);
        k = 0;
        csr_read(4'd1, rd);
        while (rd[0] && k < 20) begin
            step(); k++;
            csr_read(4'd1, rd);
        end
        check("os_busy_end", rd & 32'h301, 32'h100);
        check("os_done_lat", cyc - log_cyc[1], 3);
        csr_read(4'd0, rd);  check("os_run_clr", rd, 32'd0);
        csr_write(4'd1, 32'h100);
        csr_read(4'd1, rd);  check("os_done_w1c", rd & 32'h100, 32'd0);

        // Loop with prescale: period 1 + 2*(3+1) = 9
        csr_write(4'd8, 32'h0002_0011);
        csr_write(4'd2, 32'd3);
        csr_write(4'd3, 32'd1);
        clear_log();
        csr_write(4'd0, 32'd3);
        wait_writes("lp_nwr", 3, 60);
        check("lp_gap1", log_cyc[1] - log_cyc[0], 9);
        check("lp_gap2", log_cyc[2] - log_cyc[1], 9);
        check("lp_d2", log_data[2], 32'h11);
        step();
        csr_read(4'd1, rd);  check("lp_status", rd & 32'h371, 32'h001);
        csr_write(4'd0, 32'd0);
        csr_read(4'd1, rd);  check("lp_abort_idle", rd & 32'h301, 32'd0);

        // Dwell 0 behaves as 1: period 2 at PRESCALE 0
        csr_write(4'd8, 32'h0000_0007);
        csr_write(4'd9, 32'h0000_0008);
        csr_write(4'd3, 32'd2);
        csr_write(4'd2, 32'd0);
        clear_log();
        csr_write(4'd0, 32'd3);
        wait_writes("d0_nwr", 3, 20);
        check("d0_gap1", log_cyc[1] - log_cyc[0], 2);
        check("d0_gap2", log_cyc[2] - log_cyc[1], 2);
        check("d0_d1", log_data[1], 32'h08);
        check("d0_d2", log_data[2], 32'h07);
        csr_write(4'd0, 32'd0);

        // LENGTH 0 blocks start but RUN is stored
        csr_write(4'd3, 32'd0);
        clear_log();
        csr_write(4'd0, 32'd1);
        repeat (5) step();
        check("l0_no_pio", log_data.size(), 0);
        csr_read(4'd1, rd);  check("l0_busy", rd & 32'h1, 32'd0);
        csr_read(4'd0, rd);  check("l0_run", rd, 32'd1);
        csr_write(4'd0, 32'd0);
        csr_write(4'd3, 32'd1);

        // Manual write while idle
        clear_log();
        csr_write(4'd4, 32'h0000_001F);
        c = last_wr_cyc;
        step();
        check("man_nwr", log_data.size(), 1);
        check("man_lat", log_cyc[0] - c, 1);
        check("man_d", log_data[0], 32'h1F);

        // Manual write while busy is rejected
        csr_write(4'd8, 32'h0064_0001);
        clear_log();
        csr_write(4'd0, 32'd1);
        repeat (3) step();
        csr_write(4'd4, 32'h0000_001C);
        repeat (3) step();
        check("rej_nwr", log_data.size(), 1);
        check("rej_d", log_data[0], 32'h01);
        csr_read(4'd1, rd);  check("rej_flag", rd & 32'h200, 32'h200);
        csr_write(4'd1, 32'h200);
        csr_read(4'd1, rd);  check("rej_w1c", rd & 32'h200, 32'd0);
        csr_write(4'd0, 32'd0);

        // Abort during DWELL of entry 1, then restart from index 0
        csr_write(4'd8, 32'h0002_0015);
        csr_write(4'd9, 32'h0004_000A);
        csr_write(4'd3, 32'd2);
        clear_log();
        csr_write(4'd0, 32'd1);
        wait_writes("ab_nwr", 2, 20);
        step();
        csr_read(4'd1, rd);  check("ab_idx1", rd & 32'h071, 32'h011);
        csr_write(4'd0, 32'd0);
        csr_read(4'd1, rd);  check("ab_idle", rd & 32'h001, 32'd0);
        repeat (10) step();
        check("ab_no_more", log_data.size(), 2);
        csr_read(4'd1, rd);  check("ab_no_done", rd & 32'h100, 32'd0);
        clear_log();
        csr_write(4'd0, 32'd1);
        wait_writes("rs_nwr", 1, 5);
        check("rs_d0", log_data[0], 32'h15);
        csr_read(4'd1, rd);  check("rs_idx0", rd & 32'h071, 32'h001);
        csr_write(4'd0, 32'd0);

        step();
        check("strobe_b2b", back2back, 0);
        check("pio_addr", bad_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/soc_system_led_sequencer.md
Name: soc_system_led_sequencer

Overview:
- Avalon-MM CSR slave plus single-port Avalon-MM write master that sequences the 5-bit LED PIO (PIO data register at address 0).
- Software loads a table of up to 8 (pattern, dwell) entries; the block writes each pattern to the PIO and holds it for a programmable number of prescaled ticks, once or looping.
- Also the sole path for manual (host) LED writes, so the PIO has one master; manual writes are arbitrated against the sequencer.

Parameters:
- DEPTH, 8, pattern-table entries (max 8; fixed address window 8..15)
- LED_W, 5, LED pattern width
- DWELL_W, 16, dwell counter width (ticks)
- PRESCALE_W, 16, prescaler width

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- address  in  4  CSR word address
- chipselect  in  1  CSR select
- write_n  in  1  CSR write strobe, active-low
- writedata  in  32  CSR write data
- readdata  out  32  CSR read data, combinational from address, zero wait states
- m_chipselect  out  1  PIO chipselect
- m_write_n  out  1  PIO write strobe, active-low
- m_address  out  2  PIO address, always 0
- m_writedata  out  32  PIO write data, pattern zero-extended

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. On a clk edge with reset_n=0, all state clears.
- Reset values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0. CTRL=0, PRESCALE=0, LENGTH=1, table=0, STATUS=0, FSM=IDLE. No PIO write is issued at reset; the PIO keeps its own reset value.
- CSR map (unlisted addresses read 0, writes ignored):
  - 0 CTRL: [0] RUN, [1] LOOP.
  - 1 STATUS (RO except W1C): [0] busy, [6:4] index, [8] done (W1C), [9] reject (W1C).
  - 2 PRESCALE [15:0].
  - 3 LENGTH [3:0]. 0 is stored but blocks start; values above DEPTH are treated as DEPTH.
  - 4 MANUAL (WO): [4:0] pattern.
  - 8+i TABLE[i]: [4:0] pattern, [31:16] dwell.
- FSM states: IDLE, WRITE, DWELL, DONE.
- IDLE: a CTRL write with RUN=1 and LENGTH!=0 sets index=0 and enters WRITE next cycle. If LENGTH=0, RUN is stored but the FSM stays IDLE and busy=0.
- WRITE: lasts exactly 1 cycle. m_chipselect=1, m_write_n=0, m_writedata=TABLE[index].pattern. Prescaler is cleared; dwell counter loads max(dwell,1). Next state is DWELL.
- DWELL: a tick fires when the prescaler reaches PRESCALE, then the prescaler wraps to 0. Each tick decrements the dwell counter; on the tick that takes it to 0 the entry ends.
  - Not last entry: index++, next state WRITE.
  - Last entry (index==effective LENGTH-1), LOOP=1: index=0, next state WRITE.
  - Last entry, LOOP=0: next state DONE.
- Timing: entry period = 1 + D*(PRESCALE+1) cycles.
- DONE: for 1 cycle, sets done=1, clears CTRL.RUN, goes to IDLE. The last pattern stays on the LEDs.
- busy=1 in WRITE, DWELL and DONE.
- Abort: a CTRL write with RUN=0 while busy returns to IDLE on the next cycle. No PIO write; done is not set. An abort in the same cycle as a WRITE still completes that single-cycle PIO write.
- Manual write, not busy: a write to MANUAL issues one PIO write on the next cycle with data writedata[4:0].
- Manual write, busy: the write is dropped and reject=1.
- Live edits: TABLE writes while running take effect at that entry's next WRITE. LENGTH writes take effect at the next end-of-entry comparison; if index >= new LENGTH, treat it as the last entry. PRESCALE changes take effect at the next compare.
- Master outputs are registered; the PIO write strobe is never asserted more than 1 consecutive cycle.

Decomposition:
- Shared package/include holds:
  - CSR address constants: CTRL, STATUS, PRESCALE, LENGTH, MANUAL, TABLE_BASE.
  - STATUS/CTRL bit positions.
  - FSM state encodings.
  - PIO data address constant (0).
- One natural sub-module: soc_system_led_seq_prescaler. Inputs clk, reset_n, clear, prescale; output tick.

Test Plan:
- Reset: reset_n=0 for 2 cycles → m_chipselect=0, m_write_n=1, STATUS reads 0, LENGTH reads 1, no PIO write seen.
- One-shot run: TABLE0={0x15,dwell 2}, TABLE1={0x0A,dwell 1}, LENGTH=2, PRESCALE=0, RUN=1 → PIO writes 0x15, then 0x0A 3 cycles later, DONE 2 cycles after that; STATUS.done=1, RUN reads 0, busy=0.
- Loop with prescale: PRESCALE=3, LENGTH=1, dwell=2, LOOP=1 → PIO write of the entry every 9 cycles, index stays 0, busy stays 1.
- Dwell 0 and LENGTH 0: dwell=0 behaves as 1 (period 2 at PRESCALE=0); LENGTH=0 with RUN=1 → no PIO write, busy=0.
- Manual arbitration: idle MANUAL=0x1F → one PIO write of 0x1F next cycle; same write while busy → no extra PIO write, STATUS.reject=1; W1C to bit 9 clears it.
- Abort: RUN=0 written during DWELL → IDLE next cycle, no further PIO writes, done stays 0; a new RUN=1 restarts at index 0.
